// File: rtl/counters_pkg.sv
// Shared definitions for the counters library: direction encoding and a
// load-value clamp used by the modulus counters.
package counters_pkg;

  localparam logic CNT_DIR_UP = 1'b1;
  localparam logic CNT_DIR_DN = 1'b0;

  // Limit a value to an upper bound; callers cast to their own width.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/updn_mod_counter.sv
// Up/down modulus counter with parallel load, terminal-count decode and a
// registered wrap pulse. Define UPDN_CNT_SAT_EN to saturate instead of wrapping.
module updn_mod_counter
  import counters_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_limit;

  // Boundary in the current direction; doubles as the terminal-count decode.
  always_comb begin
    at_limit = 1'b0;
    if (up_dn == CNT_DIR_UP) at_limit = (cnt_q == MAX_VAL);
    else                     at_limit = (cnt_q == '0);
  end

  // Compare before stepping so the arithmetic never leaves 0..MAX_VAL.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX_VAL)));
    end else if (en) begin
      wrap_d = at_limit;
      if (at_limit) begin
`ifdef UPDN_CNT_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = (up_dn == CNT_DIR_UP) ? '0 : MAX_VAL;
`endif
      end else if (up_dn == CNT_DIR_UP) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign tc   = at_limit;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Self-checking bench for updn_mod_counter (WIDTH=4, MAX_VAL=9): directed
// scenarios followed by random traffic, all compared against a modulo model.
module tb_updn_mod_counter;

  localparam int unsigned W   = 4;
  localparam int          MAX = 9;

  logic         clk = 1'b0;
  logic         rst, en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         tc, wrap;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_cnt  = 0;
  int m_wrap = 0;
  bit m_valid = 1'b0;

  updn_mod_counter #(.WIDTH(W), .MAX_VAL(4'(MAX))) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference one clock edge using plain modulo arithmetic.
  task automatic model_edge(input bit r, input bit l, input int lv,
                            input bit e, input bit u);
    if (r) begin
      m_cnt = 0; m_wrap = 0; m_valid = 1'b1;
    end else if (l) begin
      m_cnt = (lv > MAX) ? MAX : lv; m_wrap = 0;
    end else if (e) begin
      if (u) begin
        m_wrap = (m_cnt == MAX);
`ifdef UPDN_CNT_SAT_EN
        if (m_cnt < MAX) m_cnt = m_cnt + 1;
`else
        m_cnt = (m_cnt + 1) % (MAX + 1);
`endif
      end else begin
        m_wrap = (m_cnt == 0);
`ifdef UPDN_CNT_SAT_EN
        if (m_cnt > 0) m_cnt = m_cnt - 1;
`else
        m_cnt = (m_cnt + MAX) % (MAX + 1);
`endif
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // Apply inputs mid-cycle, check tc before the edge, cnt/wrap after it.
  task automatic step(input string tag, input bit r, input bit l, input int lv,
                      input bit e, input bit u);
    @(negedge clk);
    rst = r; load = l; load_val = W'(lv); en = e; up_dn = u;
    #1;
    if (m_valid)
      check({tag, ".tc"}, int'(tc), (u ? (m_cnt == MAX) : (m_cnt == 0)) ? 1 : 0);
    @(posedge clk);
    model_edge(r, l, lv, e, u);
    #1;
    check({tag, ".cnt"}, int'(cnt), m_cnt);
    check({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

    step("reset", 1, 0, 0, 0, 1);
    check("reset.cnt_zero", int'(cnt), 0);

    // Count up through the wrap point
    for (int i = 0; i < 12; i++) step("up_run", 0, 0, 0, 1, 1);
`ifndef UPDN_CNT_SAT_EN
    check("up_run.final", int'(cnt), 2);
`endif

    // Load then count down through zero
    step("load3", 0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step("dn_run", 0, 0, 0, 1, 0);

    // Clamp on over-range load; load beats enable
    step("load_clamp14", 0, 1, 14, 0, 1);
    check("load_clamp14.abs", int'(cnt), MAX);
    step("load_clamp10", 0, 1, 10, 0, 1);
    step("load_max", 0, 1, 9, 0, 0);
    step("load_over_en", 0, 1, 5, 1, 1);
    check("load_over_en.abs", int'(cnt), 5);

    // Reset beats load and enable, then hold
    step("load4", 0, 1, 4, 0, 1);
    step("rst_prio", 1, 1, 7, 1, 1);
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 0, 1);

    // Direction toggling every cycle
    for (int i = 0; i < 4; i++) step("toggle", 0, 0, 0, 1, (i % 2) == 0);

    // Random traffic; reset kept rare so long runs occur
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      step("rand", sel < 2, (sel >= 2) && (sel < 10), int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
